// File: rtl/mem_line_server.sv
// Purpose : off-chip main-memory model serving 256-bit cache lines to the data cache.
// Latency : ack_o pulses LATENCY edges after a request is accepted; read data is valid during that pulse.
// Backpr. : one request in flight; enable_i is only sampled in IDLE, so new requests are accepted at most every LATENCY+2 edges.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-high reset
//   enable_i  request valid (cache mem_enable_o)
//   write_i   1 = line write, 0 = line read
//   addr_i    byte address; line index is addr_i[LINE_AW+4:5], other bits ignored
//   data_i    write line
//   ack_o     one-cycle completion pulse
//   data_o    last line read; held across writes and idle cycles
//   busy_o    high while a request is in flight (WAIT or ACK)
//
// Parameters:
//   LINE_AW   line-index width, depth = 2**LINE_AW lines
//   LATENCY   edges from acceptance to ack, legal range 2..255

module mem_line_server #(
   parameter int LINE_AW = 9,
   parameter int LATENCY = 10
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic         ack_o,
   output logic [255:0] data_o,
   output logic         busy_o
);

   localparam int         DEPTH    = 1 << LINE_AW;
   // The access fires on the edge where the counter already shows LATENCY-1,
   // which is exactly LATENCY edges after the acceptance edge cleared it.
   localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           cnt_q,   cnt_d;
   logic [LINE_AW-1:0]   idx_q,   idx_d;
   logic                 wr_q,    wr_d;
   logic [255:0]         wdat_q,  wdat_d;
   logic [255:0]         rdat_q,  rdat_d;
   logic                 mem_we;

   // Line storage; deliberately not reset so preloaded contents survive rst_i.
   logic [255:0]         line_mem [DEPTH];

   // Offset bits and aliasing high bits are intentionally dropped.
   logic                 unused_addr;
   assign unused_addr = ^{addr_i[4:0], addr_i[31:LINE_AW+5]};

   //------------------------------------------------------------------
   // Next-state and datapath
   //------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      mem_we  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               // Capture the whole request so later input changes are harmless.
               idx_d   = addr_i[LINE_AW+4:5];
               wr_d    = write_i;
               wdat_d  = data_i;
               cnt_d   = 8'd0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == LAST_CNT) begin
               state_d = ST_ACK;
               if (wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  rdat_d = line_mem[idx_q];
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_ACK: begin
            // enable_i is ignored here; the cache drops it after seeing ack.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   //------------------------------------------------------------------
   // Control and data registers
   //------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdat_q  <= '0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
      end
   end

   // A reset landing on the commit edge must not let a pending write through.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) begin
         line_mem[idx_q] <= wdat_q;
      end
   end

   //------------------------------------------------------------------
   // Outputs decode registered state only
   //------------------------------------------------------------------
   assign ack_o  = (state_q == ST_ACK);
   assign busy_o = (state_q != ST_IDLE);
   assign data_o = rdat_q;

endmodule

// File: tb/tb_mem_line_server.sv
module tb_mem_line_server;

   localparam int LINE_AW = 9;
   localparam int LAT     = 10;
   localparam int DEPTH   = 1 << LINE_AW;

   logic         clk;
   logic         rst;
   logic         enable;
   logic         write;
   logic [31:0]  addr;
   logic [255:0] wdata;
   logic         ack_o;
   logic [255:0] data_o;
   logic         busy_o;

   int n_cmp  = 0;
   int n_fail = 0;

   mem_line_server #(.LINE_AW(LINE_AW), .LATENCY(LAT)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .enable_i (enable),
      .write_i  (write),
      .addr_i   (addr),
      .data_i   (wdata),
      .ack_o    (ack_o),
      .data_o   (data_o),
      .busy_o   (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   //------------------------------------------------------------------
   // Comparison helper
   //------------------------------------------------------------------
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] pre(input int i);
      logic [31:0] w;
      w = (32'(i) * 32'h0100_0193) ^ 32'hC0FF_EE00;
      return {8{w}};
   endfunction

   //------------------------------------------------------------------
   // Reference model: one request at a time, outcome scheduled by edge
   // number. Acceptance at edge n -> access and ack at n+LAT, idle again
   // at n+LAT+1, next acceptance possible from n+LAT+2.
   //------------------------------------------------------------------
   logic [255:0]         mem_m [DEPTH];
   int                   edge_n;
   logic                 m_pend;
   int                   m_ack_edge;
   logic                 m_wr;
   logic [LINE_AW-1:0]   m_idx;
   logic [255:0]         m_wdat;
   logic                 m_ack;
   logic                 m_busy;
   logic [255:0]         m_data;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_n = 0;
         m_pend = 1'b0;
         m_ack  = 1'b0;
         m_busy = 1'b0;
         m_data = '0;
      end else begin
         edge_n = edge_n + 1;
         m_ack  = 1'b0;
         if (m_pend) begin
            if (edge_n == m_ack_edge) begin
               if (m_wr) mem_m[m_idx] = m_wdat;
               else      m_data       = mem_m[m_idx];
               m_ack = 1'b1;
            end else if (edge_n == m_ack_edge + 1) begin
               m_pend = 1'b0;
            end
         end else if (enable) begin
            m_pend     = 1'b1;
            m_ack_edge = edge_n + LAT;
            m_wr       = write;
            m_idx      = addr[LINE_AW+4:5];
            m_wdat     = wdata;
         end
         m_busy = m_pend;
      end
   end

   //------------------------------------------------------------------
   // Compare process: every falling edge outside reset
   //------------------------------------------------------------------
   int           ack_count    = 0;
   int           acc_edge_obs = 0;
   int           ack_edge_obs = 0;
   logic [255:0] ack_data_obs = '0;
   logic         busy_prev    = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         chk("ack_o",  256'(ack_o),  256'(m_ack));
         chk("busy_o", 256'(busy_o), 256'(m_busy));
         chk("data_o", data_o,       m_data);
         if (busy_o && !busy_prev) acc_edge_obs = edge_n;
         if (ack_o) begin
            ack_count++;
            ack_edge_obs = edge_n;
            ack_data_obs = data_o;
         end
         busy_prev = busy_o;
      end else begin
         busy_prev = 1'b0;
      end
   end

   //------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the falling edge)
   //------------------------------------------------------------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Lets any ACK cycle finish, then presents a one-cycle request.
   task automatic issue_req(input logic wr, input logic [31:0] a, input logic [255:0] d);
      tick();
      write  = wr;
      addr   = a;
      wdata  = d;
      enable = 1'b1;
      tick();
      enable = 1'b0;
   endtask

   task automatic wait_ack(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < LAT + 20; i++) begin
         tick();
         if (ack_o) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: no ack within %0d cycles, required one", name, LAT + 20);
      end
   endtask

   //------------------------------------------------------------------
   // Directed sequence
   //------------------------------------------------------------------
   localparam logic [255:0] PAT_A5  = {32{8'hA5}};
   localparam logic [255:0] PAT_CDE = {4{64'h0123_4567_89AB_CDEF}};
   localparam logic [255:0] PAT_D1  = {8{32'hDEAD_BEEF}};
   localparam logic [255:0] PAT_JNK = {8{32'h1111_1111}};
   localparam logic [255:0] PAT_77  = {8{32'h7777_7777}};

   initial begin
      int cnt0;
      int e1;
      int e2;

      rst    = 1'b1;
      enable = 1'b0;
      write  = 1'b0;
      addr   = '0;
      wdata  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         dut.line_mem[i] = pre(i);
         mem_m[i]        = pre(i);
      end
      dut.line_mem[3] = PAT_A5;
      mem_m[3]        = PAT_A5;

      #1;
      chk("rst_ack",  256'(ack_o),  256'd0);
      chk("rst_busy", 256'(busy_o), 256'd0);
      chk("rst_data", data_o,       256'd0);
      repeat (3) tick();
      rst = 1'b0;

      // Idle after reset: no spontaneous acks.
      repeat (20) tick();
      chk("idle_no_ack", 256'(ack_count), 256'd0);

      // Read latency on index 3.
      issue_req(1'b0, 32'h0000_0060, '0);
      wait_ack("rd_a5");
      chk("rd_latency", 256'(ack_edge_obs - acc_edge_obs), 256'd10);
      chk("rd_data",    ack_data_obs, PAT_A5);
      tick();
      chk("ack_width",  256'(ack_o), 256'd0);

      // Write then read the same line with a nonzero offset.
      issue_req(1'b1, 32'h0000_0400, PAT_CDE);
      wait_ack("wr_400");
      chk("wr_latency",   256'(ack_edge_obs - acc_edge_obs), 256'd10);
      chk("wr_keeps_data", data_o, PAT_A5);
      issue_req(1'b0, 32'h0000_041F, PAT_JNK);
      wait_ack("rd_41f");
      chk("rd_after_wr",  ack_data_obs, PAT_CDE);

      // Aliased write with inputs scrambled during WAIT.
      issue_req(1'b1, 32'h0000_4020, PAT_D1);
      addr   = 32'h0000_0060;
      wdata  = PAT_JNK;
      write  = 1'b0;
      enable = 1'b1;
      repeat (3) tick();
      enable = 1'b0;
      wait_ack("wr_4020");
      issue_req(1'b0, 32'h0000_0020, '0);
      wait_ack("rd_020");
      chk("alias_rd", ack_data_obs, PAT_D1);
      issue_req(1'b0, 32'h0000_0060, '0);
      wait_ack("rd_060");
      chk("idx3_untouched", ack_data_obs, PAT_A5);

      // Held enable across two back-to-back reads.
      tick();
      write  = 1'b0;
      addr   = 32'h0000_0060;
      enable = 1'b1;
      cnt0   = ack_count;
      e1     = 0;
      e2     = 0;
      for (int i = 0; i < 4 * LAT && ack_count < cnt0 + 2; i++) begin
         tick();
         if (ack_o && ack_count == cnt0 + 1) e1 = ack_edge_obs;
         if (ack_o && ack_count == cnt0 + 2) e2 = ack_edge_obs;
      end
      enable = 1'b0;
      chk("held_two_acks", 256'(ack_count - cnt0), 256'd2);
      chk("held_spacing",  256'(e2 - e1), 256'd12);
      chk("held_data",     ack_data_obs, PAT_A5);

      // Reset in the middle of a write to index 7.
      issue_req(1'b1, 32'h0000_00E0, PAT_77);
      repeat (5) tick();
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_ack",  256'(ack_o),  256'd0);
      chk("midrst_busy", 256'(busy_o), 256'd0);
      chk("midrst_data", data_o,       256'd0);
      tick();
      rst  = 1'b0;
      cnt0 = ack_count;
      repeat (20) tick();
      chk("midrst_no_ack", 256'(ack_count - cnt0), 256'd0);
      issue_req(1'b0, 32'h0000_00E0, '0);
      wait_ack("rd_0e0");
      chk("idx7_preserved", ack_data_obs, pre(7));

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
